// File: rtl/irq_target_ctrl_if.sv
// rtl/irq_target_ctrl_if.sv - 32-bit peripheral register bus for the hart interrupt controller
interface irq_target_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/irq_target_ctrl.sv
// rtl/irq_target_ctrl.sv - hart-side external interrupt gating, trap request and claim/complete registers
module irq_target_ctrl #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] CAUSE_EXT = 32'h8000_000B
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              plic_irq,
  input  logic [4:0]        plic_irq_id,
  input  logic              mstatus_mie,
  input  logic              mie_meie,
  output logic              trap_req,
  output logic [31:0]       trap_cause,
  input  logic              trap_ack,
  output logic [31:0]       svc_mask,
  irq_target_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_CLAIM = 2'd2,
    SERVICE    = 2'd3
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_d;
  logic [4:0]    id_q;
  logic [1:0]    err;
  logic [31:0]   served;
  logic [TW-1:0] tmo_cnt;

  logic irq_en, in_svc, sel_claim, sel_status, sel_served;
  logic claim_rd, id_match, cmpl_ok, cmpl_bad, tmo_hit;
  logic latch_id, tmo_clr, tmo_err;
  logic [1:0] err_set, err_clr;
  logic unused_bits;

  assign irq_en     = mstatus_mie & mie_meie;
  assign in_svc     = (state == WAIT_CLAIM) || (state == SERVICE);
  assign sel_claim  = (bus.addr[7:0] == 8'h00);
  assign sel_status = (bus.addr[7:0] == 8'h04);
  assign sel_served = (bus.addr[7:0] == 8'h08);
  assign claim_rd   = bus.re & sel_claim & (state == WAIT_CLAIM);
  assign id_match   = (bus.wdata[4:0] == id_q);
  assign cmpl_ok    = bus.we & sel_claim & (state == SERVICE) & id_match;
  assign cmpl_bad   = bus.we & sel_claim & (state == SERVICE) & ~id_match;
  assign tmo_hit    = in_svc & (tmo_cnt == TMO_LAST);
  assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:5], sel_served};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // A valid complete takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d  = state;
    latch_id = 1'b0;
    tmo_clr  = 1'b0;
    tmo_err  = 1'b0;
    case (state)
      IDLE: begin
        if (plic_irq && irq_en) begin
          state_d  = REQ;
          latch_id = 1'b1;
        end
      end
      REQ: begin
        if (trap_ack) begin
          state_d = WAIT_CLAIM;
          tmo_clr = 1'b1;
        end else if (!irq_en) begin
          state_d = IDLE;
        end
      end
      WAIT_CLAIM: begin
        if (tmo_hit) begin
          state_d = IDLE;
          tmo_err = 1'b1;
        end else if (claim_rd) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (cmpl_ok) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_set = {tmo_err, cmpl_bad};
  assign err_clr = (bus.we && sel_status) ? bus.wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q    <= 5'd0;
      err     <= 2'b00;
      served  <= 32'd0;
      tmo_cnt <= '0;
    end else begin
      if (latch_id) id_q <= plic_irq_id;
      err <= (err & ~err_clr) | err_set;
      if (cmpl_ok) served <= served + 32'd1;
      if (tmo_clr || !(state_d == WAIT_CLAIM || state_d == SERVICE)) tmo_cnt <= '0;
      else if (in_svc)                                                tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign trap_req   = (state == REQ);
  assign trap_cause = trap_req ? CAUSE_EXT : 32'd0;
  assign svc_mask   = in_svc ? (32'd1 << id_q) : 32'd0;

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr[7:0])
      8'h00:   bus.rdata = in_svc ? {1'b1, 26'd0, id_q} : 32'd0;
      8'h04:   bus.rdata = {22'd0, state, 6'd0, err};
      8'h08:   bus.rdata = served;
      default: bus.rdata = 32'd0;
    endcase
  end

endmodule
